// File: rtl/fetch_stage_pkg.sv
// Shared types for the IF stage: address/word types, the record handed to decode and the fetch
// FSM state encoding.
package fetch_stage_pkg;

    localparam int unsigned ADDR_W = 64;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [31:0]       u32;

    localparam addr_t RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic  valid;
        addr_t pc;
        u32    raw_instr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

    function automatic addr_t word_align(input addr_t a);
        return a & ~addr_t'(3);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one word fetch at a time, buffers a returned instruction while
// decode stalls and discards responses made stale by a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              ireq_valid,
    output logic [XLEN-1:0]   ireq_addr,
    input  logic              iresp_addr_ok,
    input  logic              iresp_data_ok,
    input  logic [31:0]       iresp_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output fetch_data_t       dataF
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    logic         pend_q, pend_d;
    addr_t        redir_q, redir_d;
    addr_t        hold_pc_q, hold_pc_d;
    u32           hold_instr_q, hold_instr_d;
    // Low for the first cycle out of reset so the request rises only after release.
    logic         live_q;

    addr_t redir_tgt;
    addr_t pc_inc;

    assign redir_tgt = word_align(redirect_pc);
    assign pc_inc    = pc_q + addr_t'(4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            redir_q      <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            live_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            redir_q      <= redir_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            live_q       <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        redir_d      = redir_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        ireq_valid   = (state_q == REQ) && live_q;
        ireq_addr    = pc_q;
        dataF        = '0;

        unique case (state_q)
            REQ: begin
                if (!live_q) begin
                    if (redirect_valid) begin
                        pc_d = redir_tgt;
                    end
                end else if (iresp_addr_ok) begin
                    pend_d = 1'b0;
                    if (redirect_valid) begin
                        redir_d = redir_tgt;
                        state_d = DRAIN;
                    end else if (pend_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (redirect_valid) begin
                    // The address is frozen until accepted; remember where to go afterwards.
                    pend_d  = 1'b1;
                    redir_d = redir_tgt;
                end
            end

            WAIT: begin
                if (iresp_data_ok) begin
                    if (redirect_valid) begin
                        pc_d    = redir_tgt;
                        state_d = REQ;
                    end else begin
                        dataF.valid     = 1'b1;
                        dataF.pc        = pc_q;
                        dataF.raw_instr = iresp_data;
                        if (stall) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = iresp_data;
                            state_d      = HOLD;
                        end else begin
                            pc_d    = pc_inc;
                            state_d = REQ;
                        end
                    end
                end else if (redirect_valid) begin
                    redir_d = redir_tgt;
                    state_d = DRAIN;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = REQ;
                end else begin
                    dataF.valid     = 1'b1;
                    dataF.pc        = hold_pc_q;
                    dataF.raw_instr = hold_instr_q;
                    if (!stall) begin
                        pc_d    = pc_inc;
                        state_d = REQ;
                    end
                end
            end

            DRAIN: begin
                if (redirect_valid) begin
                    redir_d = redir_tgt;
                end
                if (iresp_data_ok) begin
                    pc_d    = redirect_valid ? redir_tgt : redir_q;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized bus/stall/redirect traffic, all checked
// against a transaction-level model of the instruction stream seen by decode.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam addr_t RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ireq_valid;
    addr_t       ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    u32          iresp_data;
    logic        stall;
    logic        redirect_valid;
    addr_t       redirect_pc;
    fetch_data_t dataF;

    int n_tests = 0;
    int n_fail  = 0;

    // Bus responder state
    bit    outst;
    bit    req_pend;
    bit    bus_rand;
    int    addr_wait;
    int    data_cnt;
    int    lat_a;
    int    lat_d;
    addr_t resp_addr;

    // Reference model: expected pc of the next instruction decode should see
    addr_t m_pc;
    addr_t m_prev_addr;
    bit    m_stale;
    bit    m_prev_hold;
    bit    m_prev_req_wait;
    int    n_deliv = 0;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .XLEN     (64)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF          (dataF)
    );

    always #5 clk = ~clk;

    function automatic u32 mem(input addr_t a);
        return a[33:2] ^ 32'h2000_0013;
    endfunction

    function automatic int pick_lat(input int fixed);
        return bus_rand ? int'($urandom_range(0, 2)) : fixed;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc            = RST_PC;
        m_prev_addr     = '0;
        m_stale         = 1'b0;
        m_prev_hold     = 1'b0;
        m_prev_req_wait = 1'b0;
        outst           = 1'b0;
        req_pend        = 1'b0;
    endtask

    task automatic model_check();
        if (m_prev_req_wait) begin
            chk("bus_hold_valid", ireq_valid, 1);
            chk("bus_hold_addr", ireq_addr, m_prev_addr);
        end
        chk("one_outstanding", outst & ireq_valid, 0);
        if (ireq_valid && !m_prev_req_wait) begin
            chk("req_addr", ireq_addr, m_pc);
            m_stale = 1'b0;
        end
        if (redirect_valid)        chk("redir_squash", dataF.valid, 0);
        else if (iresp_data_ok)    chk(m_stale ? "stale_drop" : "pass_through", dataF.valid,
                                       !m_stale);
        else if (m_prev_hold)      chk("hold_keep", dataF.valid, 1);
        else                       chk("no_spurious", dataF.valid, 0);
        if (dataF.valid) begin
            chk("data_pc", dataF.pc, m_pc);
            chk("data_instr", dataF.raw_instr, mem(m_pc));
            chk("no_req_while_valid", ireq_valid, 0);
            if (!stall) begin
                m_pc = m_pc + addr_t'(4);
                n_deliv++;
            end
        end
        if (redirect_valid) begin
            m_pc    = redirect_pc & ~addr_t'(3);
            m_stale = 1'b1;
        end
        m_prev_hold     = dataF.valid && stall && !redirect_valid;
        m_prev_req_wait = ireq_valid && !iresp_addr_ok;
        m_prev_addr     = ireq_addr;
    endtask

    task automatic step(input logic st, input logic rv, input addr_t rpc);
        @(negedge clk);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = u32'($urandom);
        if (outst) begin
            if (data_cnt == 0) begin
                iresp_data_ok = 1'b1;
                iresp_data    = mem(resp_addr);
            end else begin
                data_cnt--;
            end
        end else if (ireq_valid) begin
            if (!req_pend) begin
                req_pend  = 1'b1;
                addr_wait = pick_lat(lat_a);
            end
            if (addr_wait == 0) iresp_addr_ok = 1'b1;
            else                addr_wait--;
        end
        #1;
        model_check();
        if (iresp_data_ok) outst = 1'b0;
        if (iresp_addr_ok) begin
            outst     = 1'b1;
            req_pend  = 1'b0;
            resp_addr = ireq_addr;
            data_cnt  = pick_lat(lat_d);
        end
    endtask

    initial begin
        addr_t tgt;
        int    deliv0;

        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        bus_rand       = 1'b0;
        lat_a          = 0;
        lat_d          = 1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ireq_valid", ireq_valid, 0);
        chk("rst_data_valid", dataF.valid, 0);
        chk("rst_data_pc", dataF.pc, 0);
        chk("rst_data_instr", dataF.raw_instr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_ireq_valid", ireq_valid, 0);

        // First fetch: addr_ok in cycle 1, data in cycle 3, no stall
        step(0, 0, '0);
        chk("t1_req_valid", ireq_valid, 1);
        chk("t1_req_addr", ireq_addr, RST_PC);
        step(0, 0, '0);
        step(0, 0, '0);
        chk("t1_valid", dataF.valid, 1);
        chk("t1_pc", dataF.pc, RST_PC);
        chk("t1_instr", dataF.raw_instr, 32'h0000_0013);
        step(0, 0, '0);
        chk("t1_next_addr", ireq_addr, RST_PC + 64'd4);

        // Stall on the data cycle and for three more cycles
        step(0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, '0);
            chk("t2_valid", dataF.valid, 1);
            chk("t2_pc", dataF.pc, RST_PC + 64'd4);
            chk("t2_no_req", ireq_valid, 0);
        end
        step(0, 0, '0);
        chk("t2_consume", dataF.valid, 1);
        step(0, 0, '0);
        chk("t2_next_addr", ireq_addr, RST_PC + 64'd8);

        // Redirect while waiting for data
        step(0, 1, 64'h8000_0100);
        step(0, 0, '0);
        chk("t3_drop", dataF.valid, 0);
        chk("t3_data_seen", iresp_data_ok, 1);
        step(0, 0, '0);
        chk("t3_target", ireq_addr, 64'h8000_0100);

        // Redirect while the request is still waiting for addr_ok
        step(0, 0, '0);
        step(0, 0, '0);
        chk("t4_pre_valid", dataF.valid, 1);
        lat_a = 3;
        step(0, 0, '0);
        chk("t4_req_addr", ireq_addr, 64'h8000_0104);
        step(0, 1, 64'h8000_0200);
        chk("t4_addr_frozen0", ireq_addr, 64'h8000_0104);
        step(0, 0, '0);
        chk("t4_addr_frozen1", ireq_addr, 64'h8000_0104);
        lat_a = 0;
        step(0, 0, '0);
        chk("t4_accept_addr", ireq_addr, 64'h8000_0104);
        step(0, 0, '0);
        step(0, 0, '0);
        chk("t4_drop", dataF.valid, 0);
        step(0, 0, '0);
        chk("t4_target", ireq_addr, 64'h8000_0200);

        // Redirect while holding a stalled instruction; unaligned target
        step(1, 0, '0);
        step(1, 0, '0);
        chk("t5_hold_valid", dataF.valid, 1);
        step(1, 0, '0);
        step(1, 1, 64'h8000_0302);
        chk("t5_squash", dataF.valid, 0);
        step(1, 0, '0);
        chk("t5_after_valid", dataF.valid, 0);
        chk("t5_target", ireq_addr, 64'h8000_0300);

        // Asynchronous reset in the middle of WAIT, on a pass-through cycle
        step(0, 0, '0);
        @(negedge clk);
        stall          = 1'b1;
        redirect_valid = 1'b0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b1;
        iresp_data     = mem(resp_addr);
        #1;
        chk("t6_pre_valid", dataF.valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", dataF.valid, 0);
        chk("t6_rst_pc", dataF.pc, 0);
        chk("t6_rst_instr", dataF.raw_instr, 0);
        chk("t6_rst_req", ireq_valid, 0);
        chk("t6_rst_addr", ireq_addr, RST_PC);
        iresp_data_ok = 1'b0;
        stall         = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("t6_rel_req", ireq_valid, 0);
        step(0, 0, '0);
        chk("t6_req_valid", ireq_valid, 1);
        chk("t6_req_addr", ireq_addr, RST_PC);

        // Randomized traffic, including targets near the top of the address space
        bus_rand = 1'b1;
        deliv0   = n_deliv;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 2))
                0:       tgt = RST_PC + addr_t'($urandom_range(0, 255));
                1:       tgt = 64'hFFFF_FFFF_FFFF_FFE0 + addr_t'($urandom_range(0, 31));
                default: tgt = {$urandom, $urandom};
            endcase
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), tgt);
        end
        chk("rand_progress", (n_deliv - deliv0) > 50, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV64 pipeline.
- Owns the PC and issues word fetches on the instruction bus with a valid/addr_ok/data_ok handshake.
- Buffers one returned instruction while decode is stalled.
- Presents fetch_data_t (valid, pc, raw_instr) to the decode stage.
- Handles redirects from execute and discards any stale in-flight response.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- XLEN, 64, PC/address width.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- ireq_valid  out  1  fetch request valid.
- ireq_addr  out  XLEN  fetch address (word aligned).
- iresp_addr_ok  in  1  request accepted this cycle.
- iresp_data_ok  in  1  response data valid this cycle.
- iresp_data  in  32  instruction word.
- stall  in  1  decode cannot accept dataF this cycle.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  XLEN  redirect target.
- dataF  out  fetch_data_t  {valid, pc[XLEN], raw_instr[32]} to decode.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - state=REQ, pc=RESET_PC, pend_redir=0.
  - ireq_valid=0 during reset; it rises in the first cycle after reset deasserts.
  - dataF.valid=0, dataF.pc=0, dataF.raw_instr=0.
- Bus rule: once ireq_valid=1, ireq_valid and ireq_addr stay stable until the cycle with iresp_addr_ok=1. At most one outstanding request.
- States:
  - REQ: ireq_valid=1, ireq_addr=pc. On addr_ok go to WAIT. Data arriving in the same cycle as addr_ok is not allowed; data_ok arrives at least one cycle later.
  - WAIT: ireq_valid=0. On data_ok:
    - If stall=0: dataF.valid=1 for that cycle (pass-through, zero added latency), pc<=pc+4, go to REQ.
    - If stall=1: capture {pc, iresp_data} into the hold register, go to HOLD.
  - HOLD: dataF.valid=1, driven from the hold register. When stall=0 the instruction is consumed, pc<=pc+4, go to REQ.
  - DRAIN: ireq_valid=0. Waits for data_ok, drops the data (dataF.valid=0), pc<=redir_target, go to REQ.
- dataF.valid is 0 in REQ and DRAIN. In WAIT it is high only on the data_ok cycle.
- Redirect, taken when redirect_valid=1 (target low 2 bits forced to 0):
  - REQ with no request yet asserted this cycle, or REQ after reset: pc<=target. The request for the new pc is issued next cycle.
  - REQ with ireq_valid=1 and addr_ok=0: the address cannot change. Latch pend_redir=1 and redir_target. On addr_ok go to DRAIN instead of WAIT.
  - REQ with addr_ok=1 in the same cycle: go to DRAIN with that target.
  - WAIT without data_ok: go to DRAIN.
  - WAIT with data_ok in the same cycle: the response is stale. dataF.valid=0, pc<=target, go to REQ.
  - HOLD: squash the hold register. dataF.valid=0 next cycle, pc<=target, go to REQ.
  - DRAIN: update redir_target (the last redirect wins).
- Redirect has priority over stall. A squashed instruction is never presented with valid=1.
- pc+4 wraps modulo 2^XLEN. No misalignment trap is generated here.
- Reset asserted mid-transaction: state returns to REQ immediately (async). Any in-flight bus response after reset is the bus's responsibility; the bus is reset by the same signal.

Decomposition:
- Package pipes: fetch_data_t {logic valid; addr_t pc; u32 raw_instr}, plus the fetch_state_t enum {REQ, WAIT, HOLD, DRAIN}.
- Package common: addr_t, u32, RESET_PC default.
- No sub-module is needed. The hold register is inline (about 200 lines).

Test Plan:
- Reset release, bus answers addr_ok at cycle 1 and data_ok=32'h00000013 at cycle 3, stall=0 -> ireq_addr=0x80000000; dataF {valid=1, pc=0x80000000, raw_instr=0x13} in cycle 3; next ireq_addr=0x80000004.
- data_ok with stall=1 held for 3 cycles -> dataF.valid=1 with the same pc/raw_instr on all 4 cycles; no new request until stall drops; next ireq_addr=pc+4.
- redirect_valid with target 0x80000100 while in WAIT -> next data_ok dropped (dataF.valid=0); following ireq_addr=0x80000100.
- redirect while ireq_valid=1 and addr_ok=0 for 2 cycles -> ireq_addr stays unchanged until addr_ok; the response is discarded; the next request goes to the redirect target.
- redirect in the HOLD state with stall=1 -> dataF.valid=0 the next cycle; ireq_addr=target; the held instruction never reappears.
- Assert reset_n=0 asynchronously mid-WAIT -> outputs zero immediately without a clock edge; after release, ireq_addr=RESET_PC.
